// File: rtl/krv_avalon_arbiter.sv
// krv_avalon_arbiter: shares one Avalon-MM master between an instruction and a data port.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module krv_avalon_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_readdata,
  output logic              imem_ack,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_writedata,
  input  logic [3:0]        dmem_byteenable,
  output logic [31:0]       dmem_readdata,
  output logic              dmem_ack,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              cpu_waitrequest
);

  // Handshake: a requester holds read/write until its one-cycle ack; the master side
  // holds every avm_* output stable while avm_waitrequest is high.
  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, RESP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q;
  logic [3:0]        starve_cnt_q;
  logic [3:0]        starve_cnt_d;
  logic [ADDR_W-1:0] avm_address_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [31:0]       avm_writedata_q;
  logic [3:0]        avm_byteenable_q;
  logic [31:0]       imem_readdata_q;
  logic [31:0]       dmem_readdata_q;
  logic              imem_ack_q;
  logic              dmem_ack_q;

  logic dmem_req;
  logic dmem_wins;
  logic imem_wins;

  assign dmem_req  = dmem_read | dmem_write;
  assign dmem_wins = dmem_req & ~(imem_read & (starve_cnt_q == STARVE_LIM));
  assign imem_wins = imem_read & ~dmem_wins;

  // Counts data grants taken while the instruction port was waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (imem_wins) begin
      starve_cnt_d = '0;
    end else if (dmem_wins && imem_read && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      starve_cnt_q     <= '0;
      avm_address_q    <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      imem_readdata_q  <= '0;
      dmem_readdata_q  <= '0;
      imem_ack_q       <= 1'b0;
      dmem_ack_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          imem_ack_q   <= 1'b0;
          dmem_ack_q   <= 1'b0;
          starve_cnt_q <= starve_cnt_d;
          if (dmem_wins) begin
            // A simultaneous read+write is carried out as a write.
            state_q          <= BUS_D;
            avm_address_q    <= dmem_addr;
            avm_write_q      <= dmem_write;
            avm_read_q       <= ~dmem_write;
            avm_writedata_q  <= dmem_write ? dmem_writedata : 32'h0;
            avm_byteenable_q <= dmem_byteenable;
          end else if (imem_wins) begin
            state_q          <= BUS_I;
            avm_address_q    <= imem_addr;
            avm_write_q      <= 1'b0;
            avm_read_q       <= 1'b1;
            avm_writedata_q  <= 32'h0;
            avm_byteenable_q <= 4'hF;
          end
        end
        BUS_I, BUS_D: begin
          if (!avm_waitrequest) begin
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            state_q     <= RESP;
            if (state_q == BUS_I) begin
              imem_readdata_q <= avm_readdata;
              imem_ack_q      <= 1'b1;
            end else begin
              if (avm_read_q) begin
                dmem_readdata_q <= avm_readdata;
              end
              dmem_ack_q <= 1'b1;
            end
          end
        end
        RESP: begin
          imem_ack_q <= 1'b0;
          dmem_ack_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign avm_address     = avm_address_q;
  assign avm_read        = avm_read_q;
  assign avm_write       = avm_write_q;
  assign avm_writedata   = avm_writedata_q;
  assign avm_byteenable  = avm_byteenable_q;
  assign imem_readdata   = imem_readdata_q;
  assign dmem_readdata   = dmem_readdata_q;
  assign imem_ack        = imem_ack_q;
  assign dmem_ack        = dmem_ack_q;
  assign cpu_waitrequest = (imem_read | dmem_read | dmem_write) & ~(imem_ack_q | dmem_ack_q);

endmodule

// File: tb/tb_krv_avalon_arbiter.sv
// tb_krv_avalon_arbiter: directed and randomized transfers checked against a
// transaction-level model of grant order, starvation limit and data capture.
module tb_krv_avalon_arbiter;

  localparam int AW   = 32;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_read = 1'b0;
  logic [AW-1:0] imem_addr = '0;
  logic [31:0]   imem_readdata;
  logic          imem_ack;
  logic          dmem_read = 1'b0;
  logic          dmem_write = 1'b0;
  logic [AW-1:0] dmem_addr = '0;
  logic [31:0]   dmem_writedata = '0;
  logic [3:0]    dmem_byteenable = '0;
  logic [31:0]   dmem_readdata;
  logic          dmem_ack;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic          cpu_waitrequest;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          starve_m = 0;
  logic [31:0] exp_ird  = '0;
  logic [31:0] exp_drd  = '0;

  always #5 clock = ~clock;

  krv_avalon_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_readdata(imem_readdata), .imem_ack(imem_ack),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_writedata(dmem_writedata), .dmem_byteenable(dmem_byteenable),
    .dmem_readdata(dmem_readdata), .dmem_ack(dmem_ack),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .cpu_waitrequest(cpu_waitrequest)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One whole transfer, entered and left at a falling edge with the arbiter idle.
  task automatic run_xfer(input int waits, input logic [31:0] rdata, output logic obs_d);
    logic          won_d;
    logic          exp_wr;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    logic [3:0]    e_be;
    won_d  = (dmem_read | dmem_write) && !(imem_read && starve_m >= SMAX);
    exp_wr = won_d && dmem_write;
    e_addr = won_d ? dmem_addr : imem_addr;
    e_wd   = exp_wr ? dmem_writedata : 32'h0;
    e_be   = won_d ? dmem_byteenable : 4'hF;
    if (won_d) begin
      if (imem_read) starve_m = (starve_m + 1 > SMAX) ? SMAX : starve_m + 1;
    end else begin
      starve_m = 0;
    end
    @(posedge clock); @(negedge clock);
    for (int k = 0; k <= waits; k++) begin
      chk32("bus_addr", avm_address, e_addr);
      chk1("bus_read", avm_read, !exp_wr);
      chk1("bus_write", avm_write, exp_wr);
      chk32("bus_wdata", avm_writedata, e_wd);
      chk32("bus_be", 32'(avm_byteenable), 32'(e_be));
      chk1("bus_iack", imem_ack, 1'b0);
      chk1("bus_dack", dmem_ack, 1'b0);
      chk1("bus_cpuwait", cpu_waitrequest, imem_read | dmem_read | dmem_write);
      avm_waitrequest = (k < waits);
      avm_readdata    = (k < waits) ? $urandom : rdata;
      if (won_d) begin
        dmem_addr       = $urandom;
        dmem_writedata  = $urandom;
        dmem_byteenable = 4'($urandom);
      end else begin
        imem_addr = $urandom;
      end
      @(posedge clock); @(negedge clock);
    end
    avm_waitrequest = 1'b0;
    obs_d = dmem_ack;
    if (!exp_wr) begin
      if (won_d) exp_drd = rdata;
      else       exp_ird = rdata;
    end
    chk1("resp_iack", imem_ack, !won_d);
    chk1("resp_dack", dmem_ack, won_d);
    chk1("resp_read", avm_read, 1'b0);
    chk1("resp_write", avm_write, 1'b0);
    chk32("resp_irdata", imem_readdata, exp_ird);
    chk32("resp_drdata", dmem_readdata, exp_drd);
    chk1("resp_cpuwait", cpu_waitrequest, (imem_read | dmem_read | dmem_write) & 1'b0);
    if (won_d) begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
    end else begin
      imem_read = 1'b0;
    end
    @(posedge clock); @(negedge clock);
    chk1("idle_iack", imem_ack, 1'b0);
    chk1("idle_dack", dmem_ack, 1'b0);
    chk1("idle_read", avm_read, 1'b0);
    chk1("idle_write", avm_write, 1'b0);
    chk1("idle_cpuwait", cpu_waitrequest, imem_read | dmem_read | dmem_write);
  endtask

  task automatic chk_all_zero(input string tag);
    chk32({tag, "_addr"}, avm_address, 32'h0);
    chk1({tag, "_read"}, avm_read, 1'b0);
    chk1({tag, "_write"}, avm_write, 1'b0);
    chk32({tag, "_wdata"}, avm_writedata, 32'h0);
    chk32({tag, "_be"}, 32'(avm_byteenable), 32'h0);
    chk32({tag, "_irdata"}, imem_readdata, 32'h0);
    chk32({tag, "_drdata"}, dmem_readdata, 32'h0);
    chk1({tag, "_iack"}, imem_ack, 1'b0);
    chk1({tag, "_dack"}, dmem_ack, 1'b0);
    chk1({tag, "_cpuwait"}, cpu_waitrequest, imem_read | dmem_read | dmem_write);
  endtask

  initial begin
    logic       obs;
    logic [1:0] op;

    // Reset state, before any clock edge.
    #1;
    chk_all_zero("rst0");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single instruction fetch, no wait states.
    imem_read = 1'b1;
    imem_addr = 32'h100;
    run_xfer(0, 32'h0000_0013, obs);
    chk1("ifetch_winner", obs, 1'b0);
    chk32("ifetch_rdata", imem_readdata, 32'h0000_0013);

    // Both ports requesting back to back: four data grants, then one instruction.
    for (int t = 0; t < 10; t++) begin
      logic e_d;
      if (!imem_read) begin
        imem_read = 1'b1;
        imem_addr = $urandom;
      end
      if (!(dmem_read | dmem_write)) begin
        dmem_read       = 1'b1;
        dmem_addr       = $urandom;
        dmem_byteenable = 4'($urandom);
      end
      e_d = ((t % 5) != 4);
      run_xfer(0, $urandom, obs);
      chk1($sformatf("order%0d", t), obs, e_d);
    end
    run_xfer(0, $urandom, obs);
    chk1("flush_winner", obs, 1'b1);

    // Data write with three wait states.
    dmem_read       = 1'b0;
    dmem_write      = 1'b1;
    dmem_addr       = 32'h2000;
    dmem_writedata  = 32'hDEAD_BEEF;
    dmem_byteenable = 4'b0011;
    run_xfer(3, 32'h5555_AAAA, obs);
    chk1("wr_winner", obs, 1'b1);

    // Read and write together behave as a write.
    dmem_read       = 1'b1;
    dmem_write      = 1'b1;
    dmem_addr       = 32'h2004;
    dmem_writedata  = 32'h1234_5678;
    dmem_byteenable = 4'hF;
    run_xfer(1, 32'h0BAD_0BAD, obs);
    chk1("rw_winner", obs, 1'b1);

    // Randomized traffic: pending requests stay up until served.
    for (int t = 0; t < 40; t++) begin
      if (!imem_read && $urandom_range(0, 2) != 0) begin
        imem_read = 1'b1;
        imem_addr = $urandom;
      end
      if (!(dmem_read | dmem_write)) begin
        op              = 2'($urandom_range(0, 3));
        dmem_read       = op[0];
        dmem_write      = op[1];
        dmem_addr       = $urandom;
        dmem_writedata  = $urandom;
        dmem_byteenable = 4'($urandom);
      end
      if (!imem_read && !dmem_read && !dmem_write) begin
        dmem_read = 1'b1;
      end
      run_xfer($urandom_range(0, 3), $urandom, obs);
    end

    // Reset in the middle of a stalled data write.
    imem_read       = 1'b0;
    dmem_read       = 1'b0;
    dmem_write      = 1'b1;
    dmem_addr       = 32'h3000;
    dmem_writedata  = 32'hCAFE_F00D;
    dmem_byteenable = 4'hF;
    avm_waitrequest = 1'b1;
    @(posedge clock); @(negedge clock);
    chk1("mid_write", avm_write, 1'b1);
    @(posedge clock); @(negedge clock);
    chk1("mid_write_held", avm_write, 1'b1);
    chk1("mid_no_ack", dmem_ack, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    exp_ird  = '0;
    exp_drd  = '0;
    starve_m = 0;
    @(posedge clock); @(negedge clock);
    chk1("rst_hold_dack", dmem_ack, 1'b0);
    chk1("rst_hold_write", avm_write, 1'b0);
    reset           = 1'b0;
    avm_waitrequest = 1'b0;
    run_xfer(1, 32'h0, obs);
    chk1("post_rst_winner", obs, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/krv_avalon_arbiter.md
KRV_AVALON_ARBITER -- requirements
Module: krv_avalon_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, Avalon address width.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, maximum consecutive dmem grants while imem waits (range 1-15).
REQ-003 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_read  in  1  instruction read request, held until imem_ack.
- imem_addr  in  ADDR_W  instruction address.
- imem_readdata  out  32  instruction read data.
- imem_ack  out  1  one-cycle completion pulse.
- dmem_read  in  1  data read request, held until dmem_ack.
- dmem_write  in  1  data write request, held until dmem_ack.
- dmem_addr  in  ADDR_W  data address.
- dmem_writedata  in  32  write data.
- dmem_byteenable  in  4  write/read byte lanes.
- dmem_readdata  out  32  data read data.
- dmem_ack  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  shared master address.
- avm_read  out  1  master read strobe.
- avm_write  out  1  master write strobe.
- avm_writedata  out  32  master write data.
- avm_byteenable  out  4  master byte enables.
- avm_readdata  in  32  slave read data, valid when waitrequest low.
- avm_waitrequest  in  1  slave stall.
- cpu_waitrequest  out  1  combined stall to the CPU.

Function
REQ-004 FSM states SHALL be IDLE, BUS_I, BUS_D, RESP; all avm_* outputs SHALL be registered.
REQ-005 In IDLE with no request, the block SHALL stay in IDLE with avm_read=avm_write=0.
REQ-006 In IDLE, dmem SHALL win when both request, unless starve_cnt==STARVE_MAX and imem_read=1, in which case imem SHALL win.
REQ-007 On grant, the block SHALL latch the winner's address, data and byteenable into avm_*; it SHALL drive avm_byteenable=4'hF for imem and avm_writedata=0 for imem and dmem reads.
REQ-008 If dmem_read and dmem_write are both set, the request SHALL be treated as a write.
REQ-009 In BUS_I/BUS_D, avm_read or avm_write SHALL stay asserted and all avm_* outputs SHALL stay stable while avm_waitrequest=1.
REQ-010 On the first BUS cycle with avm_waitrequest=0, the transfer SHALL complete; on read completion avm_readdata SHALL be captured into the granted requester's readdata, and the other readdata SHALL be unchanged.
REQ-011 The next state after completion SHALL be RESP, with avm_read=avm_write=0.
REQ-012 In RESP, exactly one of imem_ack/dmem_ack SHALL be 1 for one cycle (the granted requester), followed by an unconditional move to IDLE.
REQ-013 The requester SHALL drop or change its request in the cycle after ack; IDLE SHALL sample requests only from that cycle on.
REQ-014 Minimum transfer time SHALL be 3 cycles (IDLE grant, BUS, RESP), with one extra cycle per waitrequest cycle.
REQ-015 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, on each dmem grant made while imem_read=1.
REQ-016 starve_cnt SHALL clear on imem grant and SHALL hold otherwise.
REQ-017 Writes SHALL pulse dmem_ack and SHALL leave dmem_readdata unchanged.
REQ-018 cpu_waitrequest SHALL be combinational: (imem_read|dmem_read|dmem_write) & ~(imem_ack|dmem_ack).
REQ-019 Request inputs changing during BUS/RESP SHALL NOT affect the latched transfer.

Reset
REQ-020 While reset=1, the block SHALL asynchronously force state=IDLE, starve_cnt=0, and all outputs to 0 (avm_*, *_readdata, *_ack), with cpu_waitrequest following REQ-018.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer with no ack; the first grant SHALL occur in the first clock after reset deasserts.

Verification
REQ-022 Bench SHALL cover: imem_read, addr 0x100, waitrequest=0, readdata 0x00000013 -> avm_read for 1 cycle, imem_ack on cycle 3 with imem_readdata=0x00000013.
REQ-023 Bench SHALL cover: dmem_write, addr 0x2000, data 0xDEADBEEF, be 4'b0011, waitrequest=1 for 3 cycles -> avm_write stable for 4 cycles, then dmem_ack, with dmem_readdata unchanged.
REQ-024 Bench SHALL cover: imem and dmem continuously requesting, STARVE_MAX=4 -> grant order D,D,D,D,I, repeating.
REQ-025 Bench SHALL cover: dmem_read and dmem_write both set -> avm_write=1, avm_read=0.
REQ-026 Bench SHALL cover: reset pulsed during BUS_D with waitrequest=1 -> all outputs 0 immediately, no dmem_ack, and a new grant in the first cycle after release.
